// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl: radix-2 restoring divider sequencer producing {remainder, quotient} for HI/LO.
module mdu_div_ctrl #(
   parameter bit ZERO_FAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_op,
   input  logic        abort,
   input  logic [31:0] opr1,
   input  logic [31:0] opr2,
   output logic        stall,
   output logic        valid,
   output logic [63:0] divres
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] res_q, res_d;
   logic [32:0] sh;
   logic        ge, zero;
   logic [31:0] q_nxt, r_nxt;
   always_comb begin
      zero    = opr2 == 32'd0;
      sh      = {rem_q, quo_q[31]};
      ge      = sh >= {1'b0, dvs_q};
      q_nxt   = {quo_q[30:0], ge};
      r_nxt   = ge ? 32'(sh - {1'b0, dvs_q}) : sh[31:0];
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      if (abort)
         state_d = IDLE;
      else if (state_q == IDLE && start) begin
         if (zero && ZERO_FAST) begin
            state_d = DONE;
            res_d   = {opr1, 32'hFFFF_FFFF};
         end else begin
            state_d = CALC;
            quo_d   = (signed_op && opr1[31]) ? -opr1 : opr1;
            dvs_d   = (signed_op && opr2[31]) ? -opr2 : opr2;
            rem_d   = 32'd0;
            cnt_d   = 6'd0;
            // a zero divisor keeps the all-ones quotient un-negated so the slow path matches the fast one
            qneg_d  = signed_op & (opr1[31] ^ opr2[31]) & ~zero;
            rneg_d  = signed_op & opr1[31];
         end
      end else if (state_q == CALC) begin
         rem_d = r_nxt;
         quo_d = q_nxt;
         cnt_d = cnt_q + 6'd1;
         if (cnt_q == 6'd31) begin
            state_d = DONE;
            res_d   = {rneg_q ? -r_nxt : r_nxt, qneg_q ? -q_nxt : q_nxt};
         end
      end else if (state_q == DONE)
         state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end
   assign stall  = start & ~abort & (state_q != DONE);
   assign valid  = (state_q == DONE) & ~abort;
   assign divres = res_q;
endmodule
